// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART interrupt controller
//
// Holds the IIR interrupt codes, the IER bit layout, the FCR trigger and LCR
// word-length encodings, and two small lookup functions. One function gives
// the RX trigger level and the other gives the serial character length.
package uart_pkg;

    // IIR[3:0] identification codes. Bit 0 set means "no interrupt pending".
    typedef enum logic [3:0] {
        INT_NONE = 4'b0001,
        INT_THRE = 4'b0010,
        INT_RDA  = 4'b0100,
        INT_RLS  = 4'b0110,
        INT_CTI  = 4'b1100
    } int_code_e;

    // IER layout. The last field is bit 0.
    typedef struct packed {
        logic edssi;    // [3] modem status, no modem on this UART
        logic elsi;     // [2] receiver line status
        logic etbei;    // [1] transmitter holding register empty
        logic erbfi;    // [0] received data available / char timeout
    } int_en_s;

    typedef enum logic [1:0] {
        TRIG_1  = 2'd0,
        TRIG_4  = 2'd1,
        TRIG_8  = 2'd2,
        TRIG_14 = 2'd3
    } fifo_trig_e;

    typedef enum logic [1:0] {
        WORD_5 = 2'd0,
        WORD_6 = 2'd1,
        WORD_7 = 2'd2,
        WORD_8 = 2'd3
    } word_len_e;

    // Timeout counter width: 64 ticks x 12 bits = 768 at most.
    localparam int TMO_W = 10;

    // RX FIFO trigger level in characters.
    function automatic logic [4:0] trig_level(input fifo_trig_e trig);
        logic [4:0] lvl;
        case (trig)
            TRIG_1:  lvl = 5'd1;
            TRIG_4:  lvl = 5'd4;
            TRIG_8:  lvl = 5'd8;
            TRIG_14: lvl = 5'd14;
            default: lvl = 5'd14;
        endcase
        return lvl;
    endfunction

    // Bits per serial character: start + data + optional parity + stop(s).
    // The result is in the range 7..12.
    function automatic logic [3:0] char_bits(input word_len_e wl,
                                             input logic      parity_en,
                                             input logic      stop_bit);
        return 4'd6 + {2'b00, wl} + {3'b000, parity_en} + (stop_bit ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - RX character-timeout timer and CTI flag
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   baud_tick          16x oversample tick
//   fifo_enable        FCR[0]; the timer only runs in FIFO mode
//   word_len, parity_en, stop_bit   LCR framing, sets the threshold
//   rx_count           RX FIFO occupancy
//   rx_push, rd_rhr    RX FIFO activity, restarts the timer
//   cti                character-timeout flag
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             baud_tick,
    input  logic             fifo_enable,
    input  word_len_e        word_len,
    input  logic             parity_en,
    input  logic             stop_bit,
    input  logic [CNT_W-1:0] rx_count,
    input  logic             rx_push,
    input  logic             rd_rhr,
    output logic             cti
);

    logic [TMO_W-1:0] threshold;
    logic [TMO_W-1:0] count;
    logic [TMO_W-1:0] count_inc;
    logic             cti_clear;
    logic             restart;
    logic             reached;

    // Four character times at 16 ticks per bit: char_bits * 64.
    assign threshold = {char_bits(word_len, parity_en, stop_bit), 6'b000000};

    assign cti_clear = rx_push | rd_rhr | (rx_count == '0);
    assign restart   = cti_clear | ~fifo_enable;
    assign count_inc = count + 1'b1;

    // Compare with >= and not ==. The framing may shrink the threshold below
    // a count already reached, and the next tick must still fire.
    assign reached   = baud_tick & (count_inc >= threshold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (baud_tick) begin
            count <= reached ? threshold : count_inc;
        end
    end

    // Leaving FIFO mode resets the count but keeps the flag. The CTI source
    // is masked by fifo_enable in the prioritiser anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cti <= 1'b0;
        end else if (cti_clear) begin
            cti <= 1'b0;
        end else if (fifo_enable && reached) begin
            cti <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_intc.sv
// rtl/uart_intc.sv - 16550-style UART interrupt controller and prioritiser
//
// Build option: define UART_INTC_IRQ_REG_EN to register irq. It then lags
// int_code by one cycle and is glitch-free. Without it, irq is combinational.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_int_en          IER enables (erbfi, etbei, elsi; edssi ignored)
//   cfg_fifo_enable     FCR[0]
//   cfg_fifo_trig       RX trigger level select
//   cfg_word_len, cfg_stop_bit, cfg_parity_en   LCR framing for the timeout
//   baud_tick           16x oversample tick
//   rx_count, rx_push, rd_rhr   RX FIFO occupancy and activity
//   int_rx_line_status  pending LSR error
//   thr_empty, wr_thr   transmitter empty level and THR write strobe
//   rd_iir              IIR read strobe
//   int_code            IIR[3:0]
//   irq                 active-high level interrupt request
module uart_intc
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  int_en_s          cfg_int_en,
    input  logic             cfg_fifo_enable,
    input  fifo_trig_e       cfg_fifo_trig,
    input  word_len_e        cfg_word_len,
    input  logic             cfg_stop_bit,
    input  logic             cfg_parity_en,
    input  logic             baud_tick,
    input  logic [CNT_W-1:0] rx_count,
    input  logic             rx_push,
    input  logic             rd_rhr,
    input  logic             int_rx_line_status,
    input  logic             thr_empty,
    input  logic             wr_thr,
    input  logic             rd_iir,
    output int_code_e        int_code,
    output logic             irq
);

    logic cti;
    logic rda_level;
    logic src_rls;
    logic src_rda;
    logic src_cti;
    logic src_thre;
    logic thr_empty_q;
    logic etbei_q;
    logic thre_latch;
    logic thre_set;
    logic thre_clr;
    logic unused_edssi;

    assign unused_edssi = cfg_int_en.edssi;

    uart_rx_timeout #(
        .CNT_W (CNT_W)
    ) u_rx_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .fifo_enable (cfg_fifo_enable),
        .word_len    (cfg_word_len),
        .parity_en   (cfg_parity_en),
        .stop_bit    (cfg_stop_bit),
        .rx_count    (rx_count),
        .rx_push     (rx_push),
        .rd_rhr      (rd_rhr),
        .cti         (cti)
    );

    // In non-FIFO mode the holding register counts as one slot, so any data
    // is enough for RDA.
    assign rda_level = cfg_fifo_enable ?
                       (rx_count >= CNT_W'(trig_level(cfg_fifo_trig))) :
                       (rx_count != '0);

    assign src_rls  = cfg_int_en.elsi  & int_rx_line_status;
    assign src_rda  = cfg_int_en.erbfi & rda_level;
    assign src_cti  = cfg_int_en.erbfi & cfg_fifo_enable & cti;
    assign src_thre = cfg_int_en.etbei & thre_latch;

    always_comb begin
        int_code = INT_NONE;
        if (src_rls) begin
            int_code = INT_RLS;
        end else if (src_rda) begin
            int_code = INT_RDA;
        end else if (src_cti) begin
            int_code = INT_CTI;
        end else if (src_thre) begin
            int_code = INT_THRE;
        end
    end

    // THRE is edge-triggered. The edge detector starts primed as "empty" so
    // that leaving reset with an empty transmitter raises no spurious THRE.
    // Enabling ETBEI over an empty transmitter does raise THRE.
    assign thre_set = (thr_empty & ~thr_empty_q) |
                      (cfg_int_en.etbei & ~etbei_q & thr_empty);
    assign thre_clr = wr_thr | (rd_iir & (int_code == INT_THRE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_empty_q <= 1'b1;
            etbei_q     <= 1'b0;
            thre_latch  <= 1'b0;
        end else begin
            thr_empty_q <= thr_empty;
            etbei_q     <= cfg_int_en.etbei;
            if (thre_clr) begin
                thre_latch <= 1'b0;
            end else if (thre_set) begin
                thre_latch <= 1'b1;
            end
        end
    end

`ifdef UART_INTC_IRQ_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (int_code != INT_NONE);
        end
    end
`else
    assign irq = (int_code != INT_NONE);
`endif

endmodule

// File: tb/tb_uart_intc.sv
// tb/tb_uart_intc.sv - self-checking bench for uart_intc
module tb_uart_intc;
    import uart_pkg::*;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    int_en_s          cfg_int_en;
    logic             cfg_fifo_enable;
    fifo_trig_e       cfg_fifo_trig;
    word_len_e        cfg_word_len;
    logic             cfg_stop_bit;
    logic             cfg_parity_en;
    logic             baud_tick;
    logic [CNT_W-1:0] rx_count;
    logic             rx_push;
    logic             rd_rhr;
    logic             int_rx_line_status;
    logic             thr_empty;
    logic             wr_thr;
    logic             rd_iir;
    int_code_e        int_code;
    logic             irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_intc #(.FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_int_en         (cfg_int_en),
        .cfg_fifo_enable    (cfg_fifo_enable),
        .cfg_fifo_trig      (cfg_fifo_trig),
        .cfg_word_len       (cfg_word_len),
        .cfg_stop_bit       (cfg_stop_bit),
        .cfg_parity_en      (cfg_parity_en),
        .baud_tick          (baud_tick),
        .rx_count           (rx_count),
        .rx_push            (rx_push),
        .rd_rhr             (rd_rhr),
        .int_rx_line_status (int_rx_line_status),
        .thr_empty          (thr_empty),
        .wr_thr             (wr_thr),
        .rd_iir             (rd_iir),
        .int_code           (int_code),
        .irq                (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int trig_tab[4] = '{1, 4, 8, 14};

    bit m_prev_te;
    bit m_prev_etbei;
    bit m_thre;
    bit m_cti;
    bit m_irq_q;
    int m_idle;        // baud ticks since the RX side was last active

    function automatic int thresh();
        int bits;
        bits = 1 + 5 + int'(cfg_word_len) + int'(cfg_parity_en) + (cfg_stop_bit ? 2 : 1);
        return 64 * bits;
    endfunction

    function automatic logic [3:0] exp_code();
        bit rda;
        if (cfg_fifo_enable) rda = (int'(rx_count) >= trig_tab[int'(cfg_fifo_trig)]);
        else                 rda = (rx_count != 0);
        if (cfg_int_en[2] && int_rx_line_status)     return 4'b0110;
        if (cfg_int_en[0] && rda)                    return 4'b0100;
        if (cfg_int_en[0] && cfg_fifo_enable && m_cti) return 4'b1100;
        if (cfg_int_en[1] && m_thre)                 return 4'b0010;
        return 4'b0001;
    endfunction

    logic [3:0] m_code_now;
    bit         m_set;
    bit         m_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev_te    = 1'b1;
            m_prev_etbei = 1'b0;
            m_thre       = 1'b0;
            m_cti        = 1'b0;
            m_irq_q      = 1'b0;
            m_idle       = 0;
        end else begin
            m_code_now = exp_code();
            m_set = (thr_empty && !m_prev_te) || (cfg_int_en[1] && !m_prev_etbei && thr_empty);
            m_clr = wr_thr || (rd_iir && m_code_now == 4'b0010);
            if (m_clr)      m_thre = 1'b0;
            else if (m_set) m_thre = 1'b1;
            if (rx_push || rd_rhr || rx_count == 0) begin
                m_idle = 0;
                m_cti  = 1'b0;
            end else if (!cfg_fifo_enable) begin
                m_idle = 0;
            end else if (baud_tick) begin
                m_idle++;
                if (m_idle >= thresh()) m_cti = 1'b1;
            end
            m_prev_te    = thr_empty;
            m_prev_etbei = cfg_int_en[1];
            m_irq_q      = (m_code_now != 4'b0001);
        end
    end

    logic [3:0] e_code;
    always @(negedge clk) begin
        e_code = exp_code();
        check("model_int_code", int_code, e_code);
`ifdef UART_INTC_IRQ_REG_EN
        check("model_irq", irq, m_irq_q);
`else
        check("model_irq", irq, e_code != 4'b0001);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_code(input string name, input logic [3:0] exp);
        @(negedge clk);
        check(name, int_code, exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            step();
        end
    endtask

    task automatic pulse_rd_rhr();
        rd_rhr = 1'b1;
        step();
        rd_rhr = 1'b0;
    endtask

    int cnt;
    int len;
    int mode;

    initial begin
        rst_n              = 1'b1;
        cfg_int_en         = '0;
        cfg_fifo_enable    = 1'b0;
        cfg_fifo_trig      = TRIG_1;
        cfg_word_len       = WORD_8;
        cfg_stop_bit       = 1'b0;
        cfg_parity_en      = 1'b0;
        baud_tick          = 1'b0;
        rx_count           = '0;
        rx_push            = 1'b0;
        rd_rhr             = 1'b0;
        int_rx_line_status = 1'b0;
        thr_empty          = 1'b1;
        wr_thr             = 1'b0;
        rd_iir             = 1'b0;
        #1 rst_n = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_int_code", int_code, 4'b0001);
        check("rst_irq", irq, 1'b0);
        step();
        rst_n = 1'b1;
        step(2);
        expect_code("ier0_none", 4'b0001);

        // THRE raised by enabling ETBEI over an empty transmitter
        step();
        cfg_int_en = 4'b0010;
        expect_code("thre_not_yet", 4'b0001);
        step();
        expect_code("thre_set", 4'b0010);
        step();
        rd_iir = 1'b1;
        expect_code("iir_returns_thre", 4'b0010);
        step();
        rd_iir = 1'b0;
        expect_code("iir_clears_thre", 4'b0001);
        step(3);
        expect_code("thre_level_no_reset", 4'b0001);

        // rising edge of thr_empty, then wr_thr and rd_iir together
        thr_empty = 1'b0;
        step();
        thr_empty = 1'b1;
        expect_code("thre_edge_pending", 4'b0001);
        step();
        expect_code("thre_edge_set", 4'b0010);
        step();
        wr_thr = 1'b1;
        rd_iir = 1'b1;
        expect_code("thre_wr_rd_cycle", 4'b0010);
        step();
        wr_thr = 1'b0;
        rd_iir = 1'b0;
        expect_code("thre_wr_rd_clear", 4'b0001);
        step(3);
        expect_code("thre_stays_clear", 4'b0001);
        thr_empty = 1'b0;
        step();
        thr_empty = 1'b1;
        step();
        expect_code("thre_next_edge", 4'b0010);
        step();
        wr_thr = 1'b1;
        step();
        wr_thr     = 1'b0;
        cfg_int_en = 4'b0000;

        // RX trigger level 8 in FIFO mode
        cfg_int_en      = 4'b0001;
        cfg_fifo_enable = 1'b1;
        cfg_fifo_trig   = TRIG_8;
        for (int i = 0; i < 7; i++) begin
            rx_push = 1'b1;
            step();
            rx_push  = 1'b0;
            rx_count = rx_count + 1'b1;
        end
        expect_code("rda_7_chars", 4'b0001);
        rx_push = 1'b1;
        step();
        rx_push  = 1'b0;
        rx_count = 5'd8;
        expect_code("rda_8_chars", 4'b0100);
        step();
        pulse_rd_rhr();
        rx_count = 5'd7;
        expect_code("rda_read_to_7", 4'b0001);

        // RLS over RDA
        step();
        cfg_int_en         = 4'b0101;
        rx_count           = 5'd8;
        int_rx_line_status = 1'b1;
        expect_code("rls_over_rda", 4'b0110);
        step();
        int_rx_line_status = 1'b0;
        expect_code("rda_after_rls", 4'b0100);
        step();
        rx_count = '0;

        // character timeout, 8N1 = 10 bits -> 640 ticks
        cfg_int_en   = 4'b0001;
        cfg_word_len = WORD_8;
        rx_count     = 5'd3;
        step();
        ticks(639);
        expect_code("cti_639", 4'b0001);
        ticks(1);
        expect_code("cti_640", 4'b1100);
        step();
        pulse_rd_rhr();
        expect_code("cti_cleared", 4'b0001);
        ticks(639);
        expect_code("cti_restart_639", 4'b0001);
        ticks(1);
        expect_code("cti_restart_640", 4'b1100);

        // threshold shrinks below the running count: fires on next tick
        step();
        pulse_rd_rhr();
        ticks(500);
        expect_code("cti_500_of_640", 4'b0001);
        cfg_word_len = WORD_5;
        step();
        expect_code("cti_thr_change_no_tick", 4'b0001);
        ticks(1);
        expect_code("cti_thr_lowered", 4'b1100);
        cfg_word_len = WORD_8;
        pulse_rd_rhr();

        // asynchronous reset mid-timeout
        ticks(300);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_code", int_code, 4'b0001);
        check("async_rst_irq", irq, 1'b0);
        step();
        rst_n = 1'b1;
        ticks(639);
        expect_code("post_rst_639", 4'b0001);
        ticks(1);
        expect_code("post_rst_640", 4'b1100);
        step();

        // randomized phases against the model
        for (int p = 0; p < 25; p++) begin
            mode            = $urandom_range(0, 2);
            cfg_int_en      = 4'($urandom_range(0, 15));
            cfg_fifo_trig   = fifo_trig_e'(2'($urandom_range(0, 3)));
            cfg_word_len    = word_len_e'(2'($urandom_range(0, 3)));
            cfg_parity_en   = 1'($urandom_range(0, 1));
            cfg_stop_bit    = 1'($urandom_range(0, 1));
            cfg_fifo_enable = ($urandom_range(0, 3) != 0);
            if (mode == 0) begin
                len                = $urandom_range(600, 1200);
                rx_count           = 5'($urandom_range(1, 3));
                int_rx_line_status = 1'b0;
            end else begin
                len = $urandom_range(100, 400);
            end
            for (int c = 0; c < len; c++) begin
                baud_tick = ($urandom_range(0, 3) != 0);
                rd_iir    = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 19) == 0) thr_empty = ~thr_empty;
                wr_thr    = ($urandom_range(0, 29) == 0);
                if (mode == 0) begin
                    rx_push = ($urandom_range(0, 999) == 0);
                    rd_rhr  = 1'b0;
                end else begin
                    rx_push = ($urandom_range(0, (mode == 1) ? 99 : 5) == 0);
                    rd_rhr  = ($urandom_range(0, (mode == 1) ? 99 : 5) == 0);
                    if ($urandom_range(0, 49) == 0) int_rx_line_status = ~int_rx_line_status;
                    cnt = int'(rx_count);
                    if (rx_push && cnt < 16) cnt++;
                    else if (rd_rhr && cnt > 0) cnt--;
                    rx_count = 5'(cnt);
                end
                if ($urandom_range(0, 499) == 0) cfg_word_len = word_len_e'(2'($urandom_range(0, 3)));
                if ($urandom_range(0, 299) == 0) cfg_int_en = 4'($urandom_range(0, 15));
                step();
            end
            rx_push = 1'b0;
            rd_rhr  = 1'b0;
            rd_iir  = 1'b0;
            wr_thr  = 1'b0;
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
